// File: rtl/int_ctrl.sv
// Interrupt front-end for CP0: synchronises hw lines, latches pending bits, applies Status gating
// and holds int_com until CP0 acknowledges. Count/Compare timer enabled by INT_CTRL_TIMER_EN.
module int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter int unsigned TIMER_LINE  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int_i,
  input  logic [5:0]  int_clr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] count_i,
  input  logic [31:0] compare_i,
  input  logic        compare_we_i,
  input  logic        exc_ack_i,
  output logic [5:0]  ip_o,
  output logic        timer_int_o,
  output logic        int_com_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [2:0] TimerIdx = 3'(TIMER_LINE);

  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] sync_d [SYNC_STAGES];
  logic [5:0] s;
  logic [5:0] s_prev_q, s_prev_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] ip_q, ip_d;
  logic       timer_q, timer_d;
  logic       int_com_q, int_com_d;
  state_e     state_q, state_d;
  logic       en;
  logic [5:0] masked;

  logic unused_status;
  assign unused_status = ^{status_i[31:16], status_i[9:3]};

  always_comb begin
    sync_d[0] = hw_int_i;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign s_prev_d = s;

  // Edge lines are sticky until cleared; a fresh edge beats a simultaneous clear.
  always_comb begin
    pend_d = '0;
    for (int k = 0; k < 6; k++) begin
      if (EDGE_MASK[k]) begin
        pend_d[k] = (s[k] & ~s_prev_q[k]) | (pend_q[k] & ~int_clr_i[k]);
      end else begin
        pend_d[k] = s[k];
      end
    end
  end

`ifdef INT_CTRL_TIMER_EN
  // Compare write beats a same-cycle match; compare==0 never fires.
  always_comb begin
    timer_d = timer_q;
    if (compare_we_i) begin
      timer_d = 1'b0;
    end else if ((count_i == compare_i) && (compare_i != '0)) begin
      timer_d = 1'b1;
    end
  end
`else
  assign timer_d = 1'b0;
  logic unused_timer;
  assign unused_timer = ^{count_i, compare_i, compare_we_i};
`endif

  always_comb begin
    ip_d           = pend_d;
    ip_d[TimerIdx] = pend_d[TimerIdx] | timer_d;
  end

  assign en     = status_i[0] & ~status_i[1] & ~status_i[2];
  assign masked = ip_q & status_i[15:10];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en && (masked != '0)) state_d = StReq;
      end
      StReq: begin
        if (exc_ack_i) begin
          state_d = StWait;
        end else if (!en || (masked == '0)) begin
          state_d = StIdle;
        end
      end
      // Hold off until the handler raises EXL/ERL so en gates the next request.
      StWait: begin
        if (status_i[1] || status_i[2]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    int_com_d = (state_d == StReq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      s_prev_q  <= '0;
      pend_q    <= '0;
      ip_q      <= '0;
      timer_q   <= 1'b0;
      int_com_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      s_prev_q  <= s_prev_d;
      pend_q    <= pend_d;
      ip_q      <= ip_d;
      timer_q   <= timer_d;
      int_com_q <= int_com_d;
      state_q   <= state_d;
    end
  end

  assign ip_o        = ip_q;
  assign timer_int_o = timer_q;
  assign int_com_o   = int_com_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: history-based reference model checked every cycle plus directed literals.
module tb_int_ctrl;

  localparam int         Sync = 2;
  localparam logic [5:0] Edge = 6'b000010;
  localparam int         Tl   = 5;
`ifdef INT_CTRL_TIMER_EN
  localparam logic TimerOn = 1'b1;
`else
  localparam logic TimerOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  hw_int_i = '0;
  logic [5:0]  int_clr_i = '0;
  logic [31:0] status_i = '0;
  logic [31:0] count_i = '0;
  logic [31:0] compare_i = '0;
  logic        compare_we_i = 1'b0;
  logic        exc_ack_i = 1'b0;
  logic [5:0]  ip_o;
  logic        timer_int_o;
  logic        int_com_o;

  int total = 0;
  int bad   = 0;

  int_ctrl #(
    .SYNC_STAGES(Sync),
    .EDGE_MASK  (Edge),
    .TIMER_LINE (Tl)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hw_int_i    (hw_int_i),
    .int_clr_i   (int_clr_i),
    .status_i    (status_i),
    .count_i     (count_i),
    .compare_i   (compare_i),
    .compare_we_i(compare_we_i),
    .exc_ack_i   (exc_ack_i),
    .ip_o        (ip_o),
    .timer_int_o (timer_int_o),
    .int_com_o   (int_com_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: hw_hist[j] is the line vector seen at the (j+1)-th edge since reset.
  logic [5:0] hw_hist [$];
  logic [5:0] m_pend  = '0;
  logic       m_timer = 1'b0;
  logic [5:0] m_ip    = '0;
  logic       m_req   = 1'b0;
  logic       m_wait  = 1'b0;

  // Synchronised line value as it stood `back` edges before the latest one.
  function automatic logic [5:0] s_at(input int back);
    int idx;
    idx = hw_hist.size() - Sync - back;
    return (idx >= 0) ? hw_hist[idx] : 6'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic       en;
    logic       hit;
    logic [5:0] s1;
    logic [5:0] s2;
    if (!rst) begin
      hw_hist.delete();
      m_pend = '0; m_timer = 1'b0; m_ip = '0; m_req = 1'b0; m_wait = 1'b0;
    end else begin
      en  = status_i[0] && !status_i[1] && !status_i[2];
      hit = (m_ip & status_i[15:10]) != 0;
      if (m_wait) begin
        if (status_i[1] || status_i[2]) m_wait = 1'b0;
      end else if (m_req) begin
        if (exc_ack_i) begin
          m_req = 1'b0; m_wait = 1'b1;
        end else if (!en || !hit) begin
          m_req = 1'b0;
        end
      end else if (en && hit) begin
        m_req = 1'b1;
      end
      hw_hist.push_back(hw_int_i);
      s1 = s_at(1);
      s2 = s_at(2);
      for (int k = 0; k < 6; k++) begin
        if (Edge[k]) m_pend[k] = (s1[k] && !s2[k]) || (m_pend[k] && !int_clr_i[k]);
        else         m_pend[k] = s1[k];
      end
`ifdef INT_CTRL_TIMER_EN
      if (compare_we_i) m_timer = 1'b0;
      else if (count_i == compare_i && compare_i != 0) m_timer = 1'b1;
`endif
      m_ip = m_pend;
      m_ip[Tl] = m_pend[Tl] | m_timer;
    end
  end

  always @(negedge clk) begin
    check("ip_o", {26'b0, ip_o}, {26'b0, m_ip});
    check("timer_int_o", {31'b0, timer_int_o}, {31'b0, m_timer});
    check("int_com_o", {31'b0, int_com_o}, {31'b0, m_req});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and idle defaults
    repeat (3) @(negedge clk);
    check("rst_ip", {26'b0, ip_o}, 32'h0);
    check("rst_timer", {31'b0, timer_int_o}, 32'h0);
    check("rst_int_com", {31'b0, int_com_o}, 32'h0);
    rst = 1'b1;
    status_i = 32'h0000_FC01;
    repeat (20) @(negedge clk);
    check("idle_int_com", {31'b0, int_com_o}, 32'h0);

    // Level line 0: ip after 3 edges, request after 4
    status_i = 32'h0000_0401;
    hw_int_i = 6'b000001;
    repeat (2) @(negedge clk);
    check("lat_ip_early", {26'b0, ip_o}, 32'h0);
    @(negedge clk);
    check("lat_ip", {26'b0, ip_o}, 32'h1);
    check("lat_com_early", {31'b0, int_com_o}, 32'h0);
    @(negedge clk);
    check("lat_com", {31'b0, int_com_o}, 32'h1);
    repeat (3) @(negedge clk);
    check("com_hold", {31'b0, int_com_o}, 32'h1);
    exc_ack_i = 1'b1;
    @(negedge clk);
    exc_ack_i = 1'b0;
    check("ack_drop", {31'b0, int_com_o}, 32'h0);
    status_i = 32'h0000_0403;
    repeat (5) @(negedge clk);
    check("exl_no_rereq", {31'b0, int_com_o}, 32'h0);

    // Masking and withdraw
    status_i = 32'h0000_0001;
    repeat (5) @(negedge clk);
    check("masked_off", {31'b0, int_com_o}, 32'h0);
    status_i = 32'h0000_0401;
    @(negedge clk);
    check("unmask_req", {31'b0, int_com_o}, 32'h1);
    status_i = 32'h0000_0400;
    @(negedge clk);
    check("withdraw", {31'b0, int_com_o}, 32'h0);

    // Asynchronous reset mid-request
    status_i = 32'h0000_0401;
    @(negedge clk);
    check("pre_rst_req", {31'b0, int_com_o}, 32'h1);
    #2 rst = 1'b0;
    #1 check("async_rst_com", {31'b0, int_com_o}, 32'h0);
    check("async_rst_ip", {26'b0, ip_o}, 32'h0);
    hw_int_i = '0;
    status_i = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Edge line 1: sticky, cleared by int_clr, set beats clear
    hw_int_i = 6'b000010;
    @(negedge clk);
    hw_int_i = '0;
    repeat (2) @(negedge clk);
    check("edge_set", {26'b0, ip_o}, 32'h2);
    repeat (10) @(negedge clk);
    check("edge_sticky", {26'b0, ip_o}, 32'h2);
    int_clr_i = 6'b000010;
    @(negedge clk);
    int_clr_i = '0;
    check("edge_clr", {26'b0, ip_o}, 32'h0);
    hw_int_i = 6'b000010;
    @(negedge clk);
    hw_int_i = '0;
    @(negedge clk);
    int_clr_i = 6'b000010;
    @(negedge clk);
    int_clr_i = '0;
    check("edge_set_wins", {26'b0, ip_o}, 32'h2);
    int_clr_i = 6'b000010;
    @(negedge clk);
    int_clr_i = '0;
    check("edge_clr2", {26'b0, ip_o}, 32'h0);
    hw_int_i = 6'b000001;
    repeat (3) @(negedge clk);
    int_clr_i = 6'b000001;
    @(negedge clk);
    int_clr_i = '0;
    check("level_ignores_clr", {26'b0, ip_o}, 32'h1);
    hw_int_i = '0;
    repeat (3) @(negedge clk);

    // Timer
    compare_i = 32'd50;
    status_i = 32'h0000_8001;
    for (int c = 45; c <= 50; c++) begin
      count_i = c;
      @(negedge clk);
    end
    check("timer_fire", {31'b0, timer_int_o}, {31'b0, TimerOn});
    check("timer_ip5", {26'b0, ip_o}, {26'b0, TimerOn, 5'b0});
    count_i = 32'd51;
    @(negedge clk);
    check("timer_req", {31'b0, int_com_o}, {31'b0, TimerOn});
    count_i = 32'd52;
    exc_ack_i = 1'b1;
    @(negedge clk);
    exc_ack_i = 1'b0;
    check("timer_ack", {31'b0, int_com_o}, 32'h0);
    compare_we_i = 1'b1;
    @(negedge clk);
    compare_we_i = 1'b0;
    check("timer_we_clr", {31'b0, timer_int_o}, 32'h0);
    status_i = 32'h0000_8003;
    @(negedge clk);
    status_i = 32'h0000_8001;
    count_i = 32'd50;
    compare_we_i = 1'b1;
    @(negedge clk);
    compare_we_i = 1'b0;
    count_i = 32'd51;
    check("timer_clr_wins", {31'b0, timer_int_o}, 32'h0);
    compare_i = '0;
    for (int c = 0; c < 6; c++) begin
      count_i = c;
      @(negedge clk);
    end
    check("timer_cmp0", {31'b0, timer_int_o}, 32'h0);

    // Line 5 from hardware alone
    status_i = '0;
    hw_int_i = 6'b100000;
    repeat (3) @(negedge clk);
    check("hw5_ip", {26'b0, ip_o}, 32'h20);
    check("hw5_timer", {31'b0, timer_int_o}, 32'h0);
    hw_int_i = '0;
    repeat (3) @(negedge clk);
    check("hw5_low", {26'b0, ip_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt front-end that sits directly upstream of CP0 and drives its int_com input. Synchronises six external hardware interrupt lines and generates the Count/Compare timer interrupt. Latches pending bits, applies the Status IE/EXL/ERL/IM gating, and holds a request to CP0 until CP0 acknowledges by taking the exception jump. Also exports the Cause.IP[7:2] pending vector for CP0 to mirror.

Parameters:
SYNC_STAGES, 2, flop depth of the input synchroniser per line (legal values 2..4)
EDGE_MASK, 6'b000000, per-line trigger mode; bit k=1 means line k is rising-edge latched, 0 means level
TIMER_LINE, 5, hw line index that the timer interrupt is ORed into (IP7 for the default)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
hw_int_i  in  6  asynchronous external interrupt lines, active-high
int_clr_i  in  6  one-cycle clear pulses for edge-latched pending bits (software write to Cause)
status_i  in  32  CP0 Status: [0]=IE, [1]=EXL, [2]=ERL, [15:10]=IM7..IM2
count_i  in  32  CP0 Count
compare_i  in  32  CP0 Compare
compare_we_i  in  1  CP0 write to Compare this cycle
exc_ack_i  in  1  CP0 exc_jump_flag; CP0 has taken the exception
ip_o  out  6  registered pending vector, maps to Cause.IP[7:2]
timer_int_o  out  1  registered timer pending
int_com_o  out  1  registered interrupt request to CP0

Behaviour:
- Reset: rst low forces all flops asynchronously to 0, FSM to IDLE, and ip_o, timer_int_o and int_com_o to 0. Assertion mid-request drops int_com_o immediately.
- Synchroniser: each hw_int_i[k] passes through SYNC_STAGES flops; s[k] is the last stage.
- Level line (EDGE_MASK[k]=0): the pending bit is loaded from s[k] every cycle. int_clr_i[k] is ignored.
- Edge line (EDGE_MASK[k]=1): the pending bit is set when s[k]=1 and the previous s[k]=0. It stays set until int_clr_i[k]=1. If set and clear occur in the same cycle, set wins.
- Timer: timer_int_o is set when count_i==compare_i and compare_i!=0. It is cleared when compare_we_i=1. If set and clear occur in the same cycle, clear wins. Line TIMER_LINE of ip_o is pending[TIMER_LINE] OR timer_int_o.
- ip_o is registered and updates one clock after s/pending change.
- Enable: en = IE & ~EXL & ~ERL. masked = ip_o & status_i[15:10].
- FSM, all transitions on clk:
  IDLE: if en and masked!=0, go to REQ and set int_com_o=1.
  REQ: hold int_com_o=1. If exc_ack_i=1, go to WAIT and clear int_com_o. Otherwise, if en=0 or masked=0, withdraw: go to IDLE and clear int_com_o. exc_ack_i takes priority over withdraw.
  WAIT: int_com_o=0. Go to IDLE when status_i EXL=1 or ERL=1 (handler entered), so the next request is held off by en=0.
- Latency: a level line rising and held from clock edge E0, with gates open, gives int_com_o=1 after edge E0+SYNC_STAGES+1 (4th edge for the default).
- Width rules:
  - Count/Compare comparison is a full 32-bit equality.
  - Count wrap-around needs no special handling.
  - compare_i==0 never fires, which is the reset-safe default.

Optional Feature:
INT_CTRL_TIMER_EN.
- Defined: timer logic as described.
- Undefined: timer_int_o is tied to 0, count_i/compare_i/compare_we_i are unused, and ip_o[TIMER_LINE] is just pending[TIMER_LINE].

Test Plan:
- Reset then defaults: rst low 3 cycles then high. ip_o=0, timer_int_o=0, int_com_o=0. Status=32'h0000_FC01, all lines low, no request for 20 cycles.
- Level line, latency: Status=32'h0000_0401, hw_int_i=6'b000001 raised. ip_o=6'b000001 after 3 edges and int_com_o=1 after 4 edges. int_com_o holds until exc_ack_i=1, then 0. Status EXL set, FSM back to IDLE, no re-request.
- Masking/withdraw: Status IM2=0, line 0 high, so no int_com_o. Set IM2: request asserts. Drop IE before ack: int_com_o falls the next cycle.
- Edge line (EDGE_MASK=6'b000010): 1-cycle pulse on hw_int_i[1] latches ip_o[1]=1 permanently. int_clr_i[1] clears it. A new synced edge in the same cycle as int_clr_i keeps it set.
- Timer (macro defined): compare_i=32'd50, count_i ramps, timer_int_o=1 at count 50. ip_o[5]=1 and int_com_o=1 with IM7=1. compare_we_i clears it. A compare write in the match cycle leaves it 0. compare_i=0 never fires.
- Macro undefined: same stimulus gives timer_int_o=0 and ip_o[5] follows hw_int_i[5] only.
